// File: rtl/mu_scheduler_pkg.sv
// Shared encodings for the mu step-size scheduler: adaptation phase codes
// (as driven by the adaptation controller) and the scheduler FSM states.
package mu_scheduler_pkg;

   localparam logic [2:0] PH_STARTUP = 3'd0;
   localparam logic [2:0] PH_CMA     = 3'd1;
   localparam logic [2:0] PH_LMS     = 3'd2;

   typedef enum logic [1:0] {
      FREEZE    = 2'd0,
      CMA_RUN   = 2'd1,
      LMS_ACQ   = 2'd2,
      LMS_TRACK = 2'd3
   } sched_state_e;

   // Low-bit mask selecting the iteration_count bits that must be zero on a decay tick.
   function automatic logic [31:0] period_mask(input logic [31:0] log2);
      if (log2 >= 32'd32) return '1;
      return (32'd1 << log2) - 32'd1;
   endfunction

endpackage

// File: rtl/mu_scheduler_if.sv
// Valid/ready channel carrying step-size updates to the tap-update engine.
interface mu_scheduler_if #(
   parameter int MU_W = 16
);
   logic [MU_W-1:0] mu;
   logic            mu_valid;
   logic            mu_ready;

   modport master (output mu, output mu_valid, input mu_ready);
   modport slave  (input mu, input mu_valid, output mu_ready);
endinterface

// File: rtl/mu_decay.sv
// Combinational geometric decay of mu with a floor at mu_min; shift 0 passes mu through.
module mu_decay #(
   parameter int MU_W = 16
) (
   input  logic [MU_W-1:0] mu_i,
   input  logic [MU_W-1:0] mu_min_i,
   input  logic [3:0]      shift_i,
   output logic [MU_W-1:0] mu_o
);

   logic [MU_W-1:0] dec;

   // mu>>s never exceeds mu, so the subtraction cannot wrap.
   assign dec  = mu_i - (mu_i >> shift_i);
   assign mu_o = (shift_i == 4'd0) ? mu_i : ((dec < mu_min_i) ? mu_min_i : dec);

endmodule

// File: rtl/mu_scheduler.sv
// Step-size scheduler: tracks adaptation phase, loads per-phase initial mu,
// decays it periodically toward a floor and publishes changes over valid/ready.
module mu_scheduler
   import mu_scheduler_pkg::*;
#(
   parameter int MU_W   = 16,
   parameter int LOGP_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [2:0]        adaptation_phase,
   input  logic [31:0]       iteration_count,
   input  logic [MU_W-1:0]   mu_cma_init,
   input  logic [MU_W-1:0]   mu_lms_init,
   input  logic [MU_W-1:0]   mu_min,
   input  logic [3:0]        decay_shift,
   input  logic [LOGP_W-1:0] decay_log2,
   mu_scheduler_if.master    mu_if,
   output logic              cma_update_en,
   output logic              lms_update_en,
   output logic              tracking,
   output logic              phase_err
);

   sched_state_e    state_q, state_d;
   logic [MU_W-1:0] mu_q, mu_d, mu_dec, init_sel, init_mu;
   logic            vld_q, vld_d, pend_q, pend_d, err_q, err_d;
   logic            decaying, tick, entry;

   assign decaying = (state_q == CMA_RUN) || (state_q == LMS_ACQ);
   assign tick     = enable && decaying && (decay_shift != 4'd0) &&
                     (iteration_count != 32'd0) &&
                     ((iteration_count & period_mask(32'(decay_log2))) == 32'd0);

   mu_decay #(.MU_W(MU_W)) u_decay (
      .mu_i     (mu_q),
      .mu_min_i (mu_min),
      .shift_i  (decay_shift),
      .mu_o     (mu_dec)
   );

   always_comb begin
      state_d  = state_q;
      mu_d     = mu_q;
      vld_d    = vld_q & ~mu_if.mu_ready;
      pend_d   = pend_q;
      err_d    = err_q;
      entry    = 1'b0;
      init_sel = mu_lms_init;
      init_mu  = mu_lms_init;
      if (enable) begin
         case (adaptation_phase)
            PH_STARTUP: state_d = FREEZE;
            PH_CMA:     state_d = CMA_RUN;
            // Tracking persists while phase stays LMS; other phase codes exit as from LMS_ACQ.
            PH_LMS:     state_d = (state_q == LMS_TRACK) ? LMS_TRACK : LMS_ACQ;
            default: begin
               state_d = FREEZE;
               err_d   = 1'b1;
            end
         endcase
      end
      entry    = (state_d != state_q) && ((state_d == CMA_RUN) || (state_d == LMS_ACQ));
      init_sel = (state_d == CMA_RUN) ? mu_cma_init : mu_lms_init;
      init_mu  = (init_sel < mu_min) ? mu_min : init_sel;
      if (entry) begin
         mu_d   = init_mu;
         vld_d  = 1'b1;
         pend_d = 1'b0;
      end else if (pend_q && !vld_q) begin
         // Deferred tick lands the cycle after the previous update was taken.
         pend_d = 1'b0;
         if (decaying && (mu_dec != mu_q)) begin
            mu_d  = mu_dec;
            vld_d = 1'b1;
         end
      end else if (tick) begin
         if (vld_q && !mu_if.mu_ready) pend_d = 1'b1;
         else if (mu_dec != mu_q) begin
            mu_d  = mu_dec;
            vld_d = 1'b1;
         end
      end
      if (enable && (state_q == LMS_ACQ) && (state_d == LMS_ACQ) && (mu_d <= mu_min))
         state_d = LMS_TRACK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FREEZE;
         mu_q    <= '0;
         vld_q   <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mu_q    <= mu_d;
         vld_q   <= vld_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign mu_if.mu       = mu_q;
   assign mu_if.mu_valid = vld_q;
   assign cma_update_en  = (state_q == CMA_RUN);
   assign lms_update_en  = (state_q == LMS_ACQ) || (state_q == LMS_TRACK);
   assign tracking       = (state_q == LMS_TRACK);
   assign phase_err      = err_q;

endmodule

// File: tb/tb_mu_scheduler.sv
// Directed bench for mu_scheduler: phase entry, periodic decay, floor and
// tracking, back-pressure pending tick, illegal phase and async reset.
module tb_mu_scheduler;

   logic        clk, rst_n, enable;
   logic [2:0]  phase;
   logic [31:0] it;
   logic [15:0] cma_i, lms_i, mmin;
   logic [3:0]  dshift;
   logic [4:0]  dlog2;
   logic        cma_en, lms_en, trk, perr;
   int          n_chk, n_fail;

   mu_scheduler_if #(.MU_W(16)) mif ();

   mu_scheduler #(.MU_W(16), .LOGP_W(5)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .adaptation_phase (phase),
      .iteration_count  (it),
      .mu_cma_init      (cma_i),
      .mu_lms_init      (lms_i),
      .mu_min           (mmin),
      .decay_shift      (dshift),
      .decay_log2       (dlog2),
      .mu_if            (mif),
      .cma_update_en    (cma_en),
      .lms_update_en    (lms_en),
      .tracking         (trk),
      .phase_err        (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; enable = 1'b0; phase = 3'd0; it = 32'd0;
      cma_i = 16'h4000; lms_i = 16'h0100; mmin = 16'h0100;
      dshift = 4'd2; dlog2 = 5'd2; mif.mu_ready = 1'b1;
      #13;
      n_chk++;
      if ({mif.mu, mif.mu_valid, cma_en, lms_en, trk, perr} !== {16'h0, 5'b0}) begin
         n_fail++;
         $display("FAIL reset: mu=%h vld=%b cma=%b lms=%b trk=%b err=%b, want all 0",
                  mif.mu, mif.mu_valid, cma_en, lms_en, trk, perr);
      end
      rst_n = 1'b1;
      cyc(); cyc();
   endtask

   task automatic test_cma_entry;
      enable = 1'b1; phase = 3'd1;
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid, cma_en, lms_en} !== {16'h4000, 3'b110}) begin
         n_fail++;
         $display("FAIL cma_entry: mu=%h vld=%b cma=%b lms=%b, want 4000 1 1 0",
                  mif.mu, mif.mu_valid, cma_en, lms_en);
      end
      cyc();
      n_chk++;
      if (mif.mu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL cma_entry_vld_drop: vld=%b, want 0", mif.mu_valid);
      end
   endtask

   task automatic test_cma_decay;
      logic [15:0] exp_mu;
      logic        exp_v;
      for (int i = 1; i <= 8; i++) begin
         it = 32'(i);
         cyc();
         exp_mu = (i < 4) ? 16'h4000 : (i < 8) ? 16'h3000 : 16'h2400;
         exp_v  = (i == 4) || (i == 8);
         n_chk++;
         if ({mif.mu, mif.mu_valid} !== {exp_mu, exp_v}) begin
            n_fail++;
            $display("FAIL cma_decay it=%0d: mu=%h vld=%b, want %h %b",
                     i, mif.mu, mif.mu_valid, exp_mu, exp_v);
         end
      end
   endtask

   task automatic test_lms_floor;
      it = 32'd0; phase = 3'd2; lms_i = 16'h0100; mmin = 16'h00F0;
      dshift = 4'd3; dlog2 = 5'd0;
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid, cma_en, lms_en, trk} !== {16'h0100, 4'b1010}) begin
         n_fail++;
         $display("FAIL lms_entry: mu=%h vld=%b cma=%b lms=%b trk=%b, want 0100 1 0 1 0",
                  mif.mu, mif.mu_valid, cma_en, lms_en, trk);
      end
      it = 32'd1;
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid, lms_en, trk} !== {16'h00F0, 3'b111}) begin
         n_fail++;
         $display("FAIL lms_floor: mu=%h vld=%b lms=%b trk=%b, want 00f0 1 1 1",
                  mif.mu, mif.mu_valid, lms_en, trk);
      end
      it = 32'd2;
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid, trk} !== {16'h00F0, 2'b01}) begin
         n_fail++;
         $display("FAIL lms_track_hold: mu=%h vld=%b trk=%b, want 00f0 0 1",
                  mif.mu, mif.mu_valid, trk);
      end
   endtask

   task automatic test_backpressure;
      it = 32'd0; phase = 3'd1; cma_i = 16'h4000; mmin = 16'h0100;
      dshift = 4'd2; dlog2 = 5'd0; mif.mu_ready = 1'b0;
      cyc();
      for (int i = 1; i <= 3; i++) begin
         it = 32'(i);
         cyc();
         n_chk++;
         if ({mif.mu, mif.mu_valid, cma_en} !== {16'h4000, 2'b11}) begin
            n_fail++;
            $display("FAIL bp_hold tick=%0d: mu=%h vld=%b cma=%b, want 4000 1 1",
                     i, mif.mu, mif.mu_valid, cma_en);
         end
      end
      it = 32'd0; mif.mu_ready = 1'b1;
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid} !== {16'h4000, 1'b0}) begin
         n_fail++;
         $display("FAIL bp_accept: mu=%h vld=%b, want 4000 0", mif.mu, mif.mu_valid);
      end
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid} !== {16'h3000, 1'b1}) begin
         n_fail++;
         $display("FAIL bp_pending_apply: mu=%h vld=%b, want 3000 1", mif.mu, mif.mu_valid);
      end
      cyc(); cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid} !== {16'h3000, 1'b0}) begin
         n_fail++;
         $display("FAIL bp_single_apply: mu=%h vld=%b, want 3000 0", mif.mu, mif.mu_valid);
      end
   endtask

   task automatic test_entry_over_pending;
      mif.mu_ready = 1'b0; it = 32'd1;
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid} !== {16'h2400, 1'b1}) begin
         n_fail++;
         $display("FAIL eop_tick: mu=%h vld=%b, want 2400 1", mif.mu, mif.mu_valid);
      end
      it = 32'd2;
      cyc();
      it = 32'd0; phase = 3'd2; lms_i = 16'h0800;
      cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid, lms_en} !== {16'h0800, 2'b11}) begin
         n_fail++;
         $display("FAIL eop_entry: mu=%h vld=%b lms=%b, want 0800 1 1",
                  mif.mu, mif.mu_valid, lms_en);
      end
      enable = 1'b0; mif.mu_ready = 1'b1;
      cyc(); cyc(); cyc();
      n_chk++;
      if ({mif.mu, mif.mu_valid, trk} !== {16'h0800, 2'b00}) begin
         n_fail++;
         $display("FAIL eop_no_stale_tick: mu=%h vld=%b trk=%b, want 0800 0 0",
                  mif.mu, mif.mu_valid, trk);
      end
   endtask

   task automatic test_illegal_phase;
      enable = 1'b1; phase = 3'd5;
      cyc();
      n_chk++;
      if ({cma_en, lms_en, trk, perr} !== 4'b0001) begin
         n_fail++;
         $display("FAIL illegal: cma=%b lms=%b trk=%b err=%b, want 0 0 0 1",
                  cma_en, lms_en, trk, perr);
      end
      phase = 3'd0;
      cyc(); cyc();
      mif.mu_ready = 1'b0; phase = 3'd1; cma_i = 16'h4000;
      cyc();
      n_chk++;
      if ({perr, cma_en, mif.mu_valid, mif.mu} !== {3'b111, 16'h4000}) begin
         n_fail++;
         $display("FAIL illegal_sticky: err=%b cma=%b vld=%b mu=%h, want 1 1 1 4000",
                  perr, cma_en, mif.mu_valid, mif.mu);
      end
   endtask

   task automatic test_reset_mid;
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({mif.mu, mif.mu_valid, cma_en, lms_en, trk, perr} !== {16'h0, 5'b0}) begin
         n_fail++;
         $display("FAIL reset_mid: mu=%h vld=%b cma=%b lms=%b trk=%b err=%b, want all 0",
                  mif.mu, mif.mu_valid, cma_en, lms_en, trk, perr);
      end
      enable = 1'b0; mif.mu_ready = 1'b1;
      cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      n_chk++;
      if ({mif.mu_valid, cma_en, mif.mu} !== {2'b00, 16'h0}) begin
         n_fail++;
         $display("FAIL reset_no_valid: vld=%b cma=%b mu=%h, want 0 0 0000",
                  mif.mu_valid, cma_en, mif.mu);
      end
      enable = 1'b1;
      cyc();
      n_chk++;
      if ({mif.mu_valid, cma_en, mif.mu} !== {2'b11, 16'h4000}) begin
         n_fail++;
         $display("FAIL reset_reentry: vld=%b cma=%b mu=%h, want 1 1 4000",
                  mif.mu_valid, cma_en, mif.mu);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_cma_entry();
      test_cma_decay();
      test_lms_floor();
      test_backpressure();
      test_entry_over_pending();
      test_illegal_phase();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mu_scheduler.md
MU_SCHEDULER -- requirements
Module: mu_scheduler

Interface
REQ-001 Parameter MU_W, default 16, width of step size mu (unsigned, Q0.MU_W fraction).
REQ-002 Parameter LOGP_W, default 5, width of decay-period log2 field.
REQ-003 Ports: clk  in  1  clock; all logic rising-edge.
REQ-004 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: enable  in  1  sample strobe, same strobe driving the adaptation controller.
REQ-006 Ports: adaptation_phase  in  3  0 startup, 1 CMA, 2 LMS; 3..7 illegal.
REQ-007 Ports: iteration_count  in  32  per-phase iteration index from the adaptation controller.
REQ-008 Ports: mu_cma_init, mu_lms_init, mu_min  in  MU_W each  phase initial steps and decay floor.
REQ-009 Ports: decay_shift  in  4  decay factor: mu -= mu>>decay_shift; 0 disables decay.
REQ-010 Ports: decay_log2  in  LOGP_W  decay period = 2^decay_log2 iterations.
REQ-011 Ports: mu  out  MU_W  current step size to tap-update engine.
REQ-012 Ports: mu_valid  out  1 / mu_ready  in  1  valid/ready handshake for mu updates.
REQ-013 Ports: cma_update_en, lms_update_en  out  1 each  tap-update error-path select.
REQ-014 Ports: tracking  out  1  high once LMS mu has reached mu_min.
REQ-015 Ports: phase_err  out  1  sticky, set on illegal phase code.

Function
REQ-016 FSM states FREEZE, CMA_RUN, LMS_ACQ, LMS_TRACK; transitions evaluated only on cycles with enable=1.
REQ-017 FREEZE: cma/lms_update_en=0; phase 1 -> CMA_RUN; phase 2 -> LMS_ACQ.
REQ-018 CMA_RUN: cma_update_en=1; phase 2 -> LMS_ACQ; phase 0 -> FREEZE.
REQ-019 LMS_ACQ: lms_update_en=1; mu reaching mu_min -> LMS_TRACK; phase 0 -> FREEZE; phase 1 -> CMA_RUN.
REQ-020 LMS_TRACK: lms_update_en=1, tracking=1, mu held at mu_min; phase change exits as LMS_ACQ.
REQ-021 State entry into CMA_RUN/LMS_ACQ loads mu with mu_cma_init/mu_lms_init (clamped up to mu_min) and issues an update; 1 cycle latency from enabled phase change to new mu/mu_valid.
REQ-022 Decay tick: enable=1, state CMA_RUN or LMS_ACQ, iteration_count!=0, iteration_count[decay_log2-1:0]==0 (decay_log2=0: every iteration).
REQ-023 On tick: next = mu - (mu>>decay_shift); if next<=mu_min or decay_shift==0 result handled: next<mu_min -> mu_min; shift 0 -> no change, no update issued.
REQ-024 Each mu change asserts mu_valid; mu and mu_valid held stable until mu_valid&&mu_ready.
REQ-025 Tick while mu_valid=1 and not accepted: tick recorded in 1-bit pending flag, applied the cycle after acceptance; a second tick while pending is dropped.
REQ-026 Phase entry while update pending: entry value overwrites mu, pending decay flag cleared, mu_valid stays high.
REQ-027 Illegal phase (3..7) with enable=1: state -> FREEZE, phase_err set until reset.
REQ-028 All arithmetic unsigned MU_W bits; no wrap below zero (floor always applied).

Reset
REQ-029 rst_n low: state FREEZE, mu=0, mu_valid=0, cma_update_en=0, lms_update_en=0, tracking=0, phase_err=0, pending flag=0.
REQ-030 Reset mid-handshake discards the pending update; first post-reset mu_valid only after a phase entry.

Structure
REQ-031 Shared package holds phase encodings (STARTUP/CMA/LMS, matching the adaptation controller) and the FSM state enum.
REQ-032 Sub-module mu_decay (combinational decay+floor, MU_W-parameterised) instantiated once.

Verification
REQ-033 Phase 0->1 with mu_cma_init=0x4000, mu_ready=1 -> mu=0x4000, mu_valid one cycle, cma_update_en=1.
REQ-034 CMA, decay_log2=2, decay_shift=2, iteration_count 1..8 -> mu 0x4000->0x3000 at 4, ->0x2400 at 8.
REQ-035 LMS_ACQ mu_lms_init=0x0100, mu_min=0x00F0, decay_shift=3 -> first tick 0x00E0 floored to 0x00F0, tracking=1, state LMS_TRACK.
REQ-036 mu_ready=0 for three ticks -> one pending decay applied after acceptance, two dropped, mu stable while valid.
REQ-037 phase=5 with enable -> FREEZE, both update enables 0, phase_err=1 until rst_n.
REQ-038 rst_n asserted with mu_valid=1 -> all outputs zero asynchronously, no mu_valid until next phase entry.
